// File: rtl/spi_dev_memrd.sv
// SPI-side PSRAM reader: read command -> memif bursts -> byte stream.
// Optional macro SPI_DEV_MEMRD_UNDERRUN_EN adds a sticky underrun flag.
`timescale 1ns/1ps
module spi_dev_memrd #(
  parameter logic [7:0] CMD_BYTE   = 8'he1,
  parameter int         DATA_WIDTH = 16,
  parameter int         ADDR_WIDTH = 23,
  parameter int         BURST_LEN  = 32,
  parameter int         FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            pw_wdata,
  input  logic                  pw_wcmd,
  input  logic                  pw_wstb,
  input  logic                  pw_end,
  output logic                  pw_req,
  input  logic                  pw_gnt,
  output logic [7:0]            pw_rdata,
  output logic                  pw_rstb,
  output logic [ADDR_WIDTH-1:0] mi_addr,
  output logic [6:0]            mi_len,
  output logic                  mi_rw,
  output logic                  mi_valid,
  input  logic                  mi_ready,
  output logic [DATA_WIDTH-1:0] mi_wdata,
  input  logic                  mi_wack,
  input  logic                  mi_wlast,
  input  logic [DATA_WIDTH-1:0] mi_rdata,
  input  logic                  mi_rstb,
  input  logic                  mi_rlast
`ifdef SPI_DEV_MEMRD_UNDERRUN_EN
  ,
  output logic                  underrun
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    STREAM,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [1:0]            byte_cnt;
  logic [15:0]           addr_sr;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  valid_q;
  logic                  busy_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         resv_q;
  logic [PW-1:0]         wp_q;
  logic [PW-1:0]         rp_q;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            hi_q;
  logic                  half_q;

  logic cmd_hit;
  logic cmd_take;
  logic addr_stb;
  logic addr_last;
  logic accept;
  logic rlast_hit;
  logic in_flight;
  logic avail;
  logic take;
  logic pop;
  logic push;
  logic issue;
  logic flush;
  logic unused_ok;

  assign unused_ok = &{1'b0, mi_wack, mi_wlast};

  assign cmd_hit   = pw_wstb & pw_wcmd & (pw_wdata == CMD_BYTE);
  assign cmd_take  = (state_q == IDLE) & cmd_hit & ~pw_end;
  assign addr_stb  = pw_wstb & ~pw_wcmd;
  assign addr_last = (state_q == ADDR) & addr_stb
                   & (byte_cnt == 2'd2) & ~pw_end;
  assign accept    = valid_q & mi_ready;
  assign rlast_hit = mi_rstb & mi_rlast & busy_q;
  assign in_flight = valid_q | (busy_q & ~rlast_hit);
  assign avail     = (cnt_q != '0) | half_q;
  assign pw_req    = (state_q == STREAM) & avail;
  assign take      = pw_gnt & pw_req & ~pw_end;
  assign pop       = take & ~half_q;
  assign push      = mi_rstb & busy_q & (state_q == STREAM);
  assign rd_word   = mem[rp_q];

  // Free space counts words still owed by the burst in flight.
  assign issue = (state_q == STREAM) & ~pw_end
               & ~valid_q & ~busy_q
               & ((cnt_q + resv_q) <= CW'(FIFO_DEPTH - BURST_LEN));

  assign flush = (state_q != IDLE) & (state_d == IDLE);

  assign mi_addr  = word_addr;
  assign mi_valid = valid_q;
  assign mi_len   = valid_q ? 7'(BURST_LEN - 1) : 7'd0;
  assign mi_rw    = 1'b1;
  assign mi_wdata = '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_take) state_d = ADDR;
      end
      ADDR: begin
        if (pw_end) state_d = IDLE;
        else if (addr_last) state_d = STREAM;
      end
      STREAM: begin
        if (pw_end) state_d = in_flight ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (rlast_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      addr_sr   <= '0;
      word_addr <= '0;
    end else begin
      if (cmd_take) byte_cnt <= '0;
      else if ((state_q == ADDR) & addr_stb) begin
        byte_cnt <= byte_cnt + 2'd1;
        addr_sr  <= {addr_sr[7:0], pw_wdata};
      end
      // Byte-address bit 0 is dropped to form the word address.
      if (addr_last)
        word_addr <= ADDR_WIDTH'({addr_sr, pw_wdata[7:1]});
      else if (accept)
        word_addr <= word_addr + ADDR_WIDTH'(BURST_LEN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      resv_q  <= '0;
    end else begin
      if (issue)       valid_q <= 1'b1;
      else if (accept) valid_q <= 1'b0;
      if (accept)         busy_q <= 1'b1;
      else if (rlast_hit) busy_q <= 1'b0;
      if (flush | rlast_hit) resv_q <= '0;
      else if (accept)       resv_q <= CW'(BURST_LEN);
      else if (push)         resv_q <= resv_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= mi_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PW'(1);
      if (pop)  rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_rdata <= '0;
      pw_rstb  <= 1'b0;
      hi_q     <= '0;
      half_q   <= 1'b0;
    end else begin
      pw_rstb <= take;
      if (flush) half_q <= 1'b0;
      else if (take) begin
        if (half_q) begin
          pw_rdata <= hi_q;
          half_q   <= 1'b0;
        end else begin
          pw_rdata <= rd_word[7:0];
          hi_q     <= rd_word[15:8];
          half_q   <= 1'b1;
        end
      end
    end
  end

`ifdef SPI_DEV_MEMRD_UNDERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underrun <= 1'b0;
    else if (cmd_take) underrun <= 1'b0;
    else if (pw_gnt & (state_q == STREAM) & ~avail)
      underrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_spi_dev_memrd.sv
// Directed bench for spi_dev_memrd with a simple memif responder.
// Define SPI_DEV_MEMRD_UNDERRUN_EN to also exercise the underrun flag.
`timescale 1ns/1ps
module tb_spi_dev_memrd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pw_wdata;
  logic        pw_wcmd;
  logic        pw_wstb;
  logic        pw_end;
  logic        pw_req;
  logic        pw_gnt;
  logic [7:0]  pw_rdata;
  logic        pw_rstb;
  logic [22:0] mi_addr;
  logic [6:0]  mi_len;
  logic        mi_rw;
  logic        mi_valid;
  logic        mi_ready;
  logic [15:0] mi_wdata;
  logic        mi_wack = 1'b0;
  logic        mi_wlast = 1'b0;
  logic [15:0] mi_rdata;
  logic        mi_rstb;
  logic        mi_rlast;
`ifdef SPI_DEV_MEMRD_UNDERRUN_EN
  logic        underrun;
`endif

  always #5 clk = ~clk;

  spi_dev_memrd dut (
    .clk(clk), .rst_n(rst_n),
    .pw_wdata(pw_wdata), .pw_wcmd(pw_wcmd),
    .pw_wstb(pw_wstb), .pw_end(pw_end),
    .pw_req(pw_req), .pw_gnt(pw_gnt),
    .pw_rdata(pw_rdata), .pw_rstb(pw_rstb),
    .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw),
    .mi_valid(mi_valid), .mi_ready(mi_ready),
    .mi_wdata(mi_wdata), .mi_wack(mi_wack),
    .mi_wlast(mi_wlast), .mi_rdata(mi_rdata),
    .mi_rstb(mi_rstb), .mi_rlast(mi_rlast)
`ifdef SPI_DEV_MEMRD_UNDERRUN_EN
    , .underrun(underrun)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          lat_err = 0;
  int          ovl_err = 0;
  int          delivered = 0;
  int          ridx = 0;
  int          rleft = 0;
  logic [22:0] rbase = '0;
  logic        ready_en = 1'b0;
  logic        mv_seen = 1'b0;
  logic        req_seen = 1'b0;
  logic [7:0]  rx[$];
  logic [22:0] acc[$];

  function automatic logic [15:0] mem_word(input logic [22:0] a);
    if (a == 23'h000800) return 16'h1234;
    if (a == 23'h000801) return 16'h5678;
    return {a[7:0], a[15:8] ^ 8'h3c};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [22:0] base,
                                          input int i);
    logic [15:0] w;
    w = mem_word(base + 23'(i / 2));
    return (i % 2 == 1) ? w[15:8] : w[7:0];
  endfunction

  // Memory side: accepts a burst, then returns one word per cycle.
  initial begin
    mi_ready = 1'b0;
    mi_rstb  = 1'b0;
    mi_rlast = 1'b0;
    mi_rdata = '0;
    forever begin
      @(negedge clk);
      mi_rstb  = 1'b0;
      mi_rlast = 1'b0;
      if (rleft > 0) begin
        mi_rdata = mem_word(rbase + 23'(ridx));
        mi_rstb  = 1'b1;
        mi_rlast = (rleft == 1);
        ridx++;
        rleft--;
        delivered++;
      end
      mi_ready = ready_en;
      if (mi_valid && mi_ready) begin
        if (rleft > 0) ovl_err++;
        acc.push_back(mi_addr);
        rbase = mi_addr;
        ridx  = 0;
        rleft = int'(mi_len) + 1;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic e;
    e = pw_gnt & pw_req & ~pw_end;
    @(negedge clk);
    if (pw_rstb !== e) lat_err++;
    if (pw_rstb) rx.push_back(pw_rdata);
    if (mi_valid) mv_seen = 1'b1;
    if (pw_req) req_seen = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic c);
    pw_wdata = b;
    pw_wcmd  = c;
    pw_wstb  = 1'b1;
    step();
    pw_wstb  = 1'b0;
    pw_wcmd  = 1'b0;
  endtask

  task automatic open(input logic [7:0] a2, input logic [7:0] a1,
                      input logic [7:0] a0);
    send(8'he1, 1'b1);
    send(a2, 1'b0);
    send(a1, 1'b0);
    send(a0, 1'b0);
  endtask

  task automatic end_txn();
    pw_gnt = 1'b0;
    pw_end = 1'b1;
    step();
    pw_end = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < 400) begin
      step();
      n++;
      if (rleft == 0 && !mi_valid && !pw_req) quiet++;
      else quiet = 0;
    end
    chk(tag, 32'(quiet >= 4), 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!mi_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic grant(input int nb);
    int g = 0;
    int n = 0;
    while (g < nb && n < 200) begin
      pw_gnt = pw_req;
      if (pw_req) g++;
      step();
      n++;
    end
    pw_gnt = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int occ;
    int maxocc;
    int bad;
    pw_wdata = '0;
    pw_wcmd  = 1'b0;
    pw_wstb  = 1'b0;
    pw_end   = 1'b0;
    pw_gnt   = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ctl", {29'd0, pw_req, pw_rstb, mi_valid, mi_rw}, 32'h1);
    chk("rst_rdata", pw_rdata, 32'h0);
    chk("rst_addr", mi_addr, 32'h0);
    chk("rst_len", mi_len, 32'h0);
    chk("rst_wdata", mi_wdata, 32'h0);
`ifdef SPI_DEV_MEMRD_UNDERRUN_EN
    chk("rst_underrun", underrun, 32'h0);
`endif
    rst_n = 1'b1;
    step();

    // Basic read: first burst and its first 8 bytes.
    ready_en = 1'b0;
    rx.delete();
    acc.delete();
    lat_err = 0;
    open(8'h00, 8'h10, 8'h00);
    wait_valid();
    chk("t1_valid", mi_valid, 32'h1);
    chk("t1_addr", mi_addr, 32'h800);
    chk("t1_len", mi_len, 32'd31);
    chk("t1_rw", mi_rw, 32'h1);
    ready_en = 1'b1;
    grant(8);
    chk("t1_nbytes", rx.size(), 32'd8);
    chk("t1_b0", rx[0], 32'h34);
    chk("t1_b1", rx[1], 32'h12);
    chk("t1_b2", rx[2], 32'h78);
    chk("t1_b3", rx[3], 32'h56);
    chk("t1_b7", rx[7], 32'(exp_byte(23'h800, 7)));
    chk("t1_latency", lat_err, 32'd0);
    end_txn();
    wait_idle("t1_idle");

    // Long read with continuous grant.
    rx.delete();
    acc.delete();
    lat_err = 0;
    ovl_err = 0;
    open(8'h00, 8'h10, 8'h00);
    delivered = 0;
    maxocc = 0;
    pw_gnt = 1'b1;
    n = 0;
    while (rx.size() < 256 && n < 3000) begin
      step();
      n++;
      occ = delivered - (rx.size() + 1) / 2;
      if (occ > maxocc) maxocc = occ;
    end
    pw_gnt = 1'b0;
    chk("t2_nbytes", rx.size(), 32'd256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (rx[i] !== exp_byte(23'h800, i)) bad++;
    chk("t2_data", bad, 32'd0);
    chk("t2_acc0", acc[0], 32'h800);
    chk("t2_acc1", acc[1], 32'h820);
    chk("t2_acc2", acc[2], 32'h840);
    chk("t2_acc3", acc[3], 32'h860);
    chk("t2_overlap", ovl_err, 32'd0);
    chk("t2_occupancy", 32'(maxocc <= 64), 32'd1);
    chk("t2_latency", lat_err, 32'd0);
    end_txn();
    wait_idle("t2_idle");

    // Address wrap at the top of memory.
    acc.delete();
    ready_en = 1'b0;
    open(8'hff, 8'hff, 8'hfe);
    wait_valid();
    chk("t3_addr", mi_addr, 32'h7fffff);
    ready_en = 1'b1;
    n = 0;
    while (acc.size() < 2 && n < 300) begin
      step();
      n++;
    end
    chk("t3_acc0", acc[0], 32'h7fffff);
    chk("t3_acc1", acc[1], 32'h1f);
    n = 0;
    while (rleft > 0 && n < 100) begin
      step();
      n++;
    end
    end_txn();
    wait_idle("t3_idle");

    // Abort mid-burst: rest of the burst is discarded.
    acc.delete();
    rx.delete();
    lat_err = 0;
    open(8'h00, 8'h10, 8'h00);
    n = 0;
    while ((rleft == 0 || ridx < 10) && n < 100) begin
      step();
      n++;
    end
    end_txn();
    step();
    chk("t4_req", pw_req, 32'h0);
    pw_gnt = 1'b1;
    n = 0;
    while (rleft > 0 && n < 100) begin
      step();
      n++;
    end
    pw_gnt = 1'b0;
    step();
    step();
    chk("t4_norx", rx.size(), 32'd0);
    chk("t4_req_end", pw_req, 32'h0);
    chk("t4_nburst", acc.size(), 32'd1);
    open(8'h00, 8'h20, 8'h00);
    grant(4);
    chk("t4_acc", acc[1], 32'h1000);
    chk("t4_b0", rx[0], 32'h2c);
    chk("t4_b1", rx[1], 32'h00);
    chk("t4_b2", rx[2], 32'h2c);
    chk("t4_b3", rx[3], 32'h01);
    chk("t4_latency", lat_err, 32'd0);
    end_txn();
    wait_idle("t4_idle");

    // Wrong command and truncated address: no memif activity.
    acc.delete();
    mv_seen = 1'b0;
    req_seen = 1'b0;
    send(8'he0, 1'b1);
    send(8'h00, 1'b0);
    send(8'h10, 1'b0);
    send(8'h00, 1'b0);
    repeat (10) step();
    chk("t5_badcmd_valid", mv_seen, 32'h0);
    chk("t5_badcmd_req", req_seen, 32'h0);
    send(8'he1, 1'b1);
    send(8'h00, 1'b0);
    send(8'h10, 1'b0);
    end_txn();
    send(8'h00, 1'b0);
    repeat (10) step();
    chk("t5_short_valid", mv_seen, 32'h0);
    chk("t5_short_req", req_seen, 32'h0);
    chk("t5_nburst", acc.size(), 32'd0);

`ifdef SPI_DEV_MEMRD_UNDERRUN_EN
    lat_err = 0;
    ready_en = 1'b0;
    open(8'h00, 8'h10, 8'h00);
    repeat (3) step();
    chk("u_clear", underrun, 32'h0);
    pw_gnt = 1'b1;
    step();
    pw_gnt = 1'b0;
    chk("u_rstb", pw_rstb, 32'h0);
    step();
    chk("u_set", underrun, 32'h1);
    ready_en = 1'b1;
    end_txn();
    wait_idle("u_idle");
    chk("u_sticky", underrun, 32'h1);
    send(8'he1, 1'b1);
    step();
    chk("u_cmd_clear", underrun, 32'h0);
    send(8'h00, 1'b0);
    send(8'h10, 1'b0);
    send(8'h00, 1'b0);
    end_txn();
    wait_idle("u_idle2");
    chk("u_latency", lat_err, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
